// File: rtl/gpu_fb_writer.sv
// ---------------------------------------------------------------------------
// gpu_fb_writer
//
// Accepts rasterised pixel beats from the GPU pipeline, clips them against the
// framebuffer bounds, turns (x, y) into a linear word address, queues the
// writes in a small FIFO and issues them to the framebuffer memory with a
// valid/ready style handshake (fb_wr_en held stable until fb_wr_ready).
//
// Pipeline:  accept -> address register -> write FIFO -> write output register
//
// Optional build feature (macro GPU_FB_DOUBLE_BUFFER_EN):
//   The base address alternates between 0 and FB_WIDTH*FB_HEIGHT, toggling on
//   every frame_done pulse. The extra output front_buffer shows the select bit.
//   Without the macro the base is fixed at 0 and front_buffer does not exist.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-low reset
//   enable         level, allows pixel acceptance
//   pixel_valid    pixel beat valid from the GPU
//   pixel_ready    beat accepted when pixel_valid && pixel_ready
//   pixel_x/_y     11-bit pixel coordinates
//   pixel_color    8-bit pixel value
//   pixel_draw     1 = write the pixel, 0 = consume and discard the beat
//   frame_end_in   end-of-frame marker, sampled every cycle in RUN
//   fb_wr_addr     20-bit linear framebuffer word address
//   fb_wr_data     8-bit write data
//   fb_wr_en       write request, held with addr/data until fb_wr_ready
//   fb_wr_ready    memory accepts the write this cycle
//   front_buffer   (double-buffer build only) buffer select after toggling
//   frame_done     one-cycle pulse when a frame has been fully written
//   clip_count     saturating count of out-of-range pixels with draw=1
// ---------------------------------------------------------------------------
module gpu_fb_writer #(
  parameter int FB_WIDTH   = 800,
  parameter int FB_HEIGHT  = 600,
  parameter int FIFO_DEPTH = 16   // power of two, >= 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [7:0]  pixel_color,
  input  logic        pixel_draw,
  input  logic        frame_end_in,
  output logic [19:0] fb_wr_addr,
  output logic [7:0]  fb_wr_data,
  output logic        fb_wr_en,
  input  logic        fb_wr_ready,
`ifdef GPU_FB_DOUBLE_BUFFER_EN
  output logic        front_buffer,
`endif
  output logic        frame_done,
  output logic [15:0] clip_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [10:0] FB_WIDTH_C  = 11'(FB_WIDTH);
  localparam logic [10:0] FB_HEIGHT_C = 11'(FB_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state;

  // Address stage
  logic        s1_valid;
  logic [19:0] s1_addr;
  logic [7:0]  s1_color;

  // Write FIFO, entries are {addr, color}
  logic [27:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic        accept;
  logic        in_range;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        pipe_empty;
  logic [19:0] base;
  logic [19:0] pix_addr;

  // -------------------------------------------------------------------------
  // Front end: acceptance, clipping, address arithmetic
  // -------------------------------------------------------------------------

  // "Full" reserves one slot for the entry sitting in the address stage, so a
  // beat accepted now can never find the FIFO without room one cycle later.
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH)) ||
                     (s1_valid && (fifo_count == CW'(FIFO_DEPTH - 1)));

  assign pixel_ready = (state == ST_RUN) && enable && !fifo_full;
  assign accept      = pixel_valid && pixel_ready;
  assign in_range    = (pixel_x < FB_WIDTH_C) && (pixel_y < FB_HEIGHT_C);

`ifdef GPU_FB_DOUBLE_BUFFER_EN
  logic buf_sel;

  assign base         = buf_sel ? 20'(FB_WIDTH * FB_HEIGHT) : 20'd0;
  assign front_buffer = buf_sel;
`else
  assign base = 20'd0;
`endif

  // Largest address is 2*800*600-1, which fits in 20 bits unsigned.
  assign pix_addr = 20'(pixel_x) + 20'(pixel_y) * 20'(FB_WIDTH) + base;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= 20'd0;
      s1_color <= 8'd0;
    end else begin
      // Discarded (draw=0) and clipped beats are consumed here and never
      // reach the FIFO.
      s1_valid <= accept && pixel_draw && in_range;
      if (accept) begin
        s1_addr  <= pix_addr;
        s1_color <= pixel_color;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_count <= 16'd0;
    end else if (accept && pixel_draw && !in_range && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Write FIFO
  // -------------------------------------------------------------------------
  assign fifo_push = s1_valid;
  // Refill the output register when it is empty or its write completes now.
  assign fifo_pop  = (fifo_count != '0) && (!fb_wr_en || fb_wr_ready);

  // NOTE: the storage array has no reset; the pointers and count decide what
  // is valid, so clearing the data itself would only cost reset routing.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {s1_addr, s1_color};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write output register: address/data stay stable while fb_wr_en waits
  // for fb_wr_ready.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= 20'd0;
      fb_wr_data <= 8'd0;
    end else if (fifo_pop) begin
      fb_wr_en                 <= 1'b1;
      {fb_wr_addr, fb_wr_data} <= fifo_mem[rd_ptr];
    end else if (fb_wr_ready) begin
      fb_wr_en <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  assign pipe_empty = (fifo_count == '0) && !s1_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
`ifdef GPU_FB_DOUBLE_BUFFER_EN
      buf_sel    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          // A beat accepted in the frame_end_in cycle is already in the
          // address stage when DRAIN starts, so it is still written.
          if (frame_end_in) begin
            state <= ST_DRAIN;
          end else if (!enable && pipe_empty) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Wait for the last write to be accepted by the memory as well.
          if (pipe_empty && !fb_wr_en) begin
            frame_done <= 1'b1;
`ifdef GPU_FB_DOUBLE_BUFFER_EN
            buf_sel    <= !buf_sel;
`endif
            state      <= enable ? ST_RUN : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_fb_writer.sv
`timescale 1ns/1ps
// Directed testbench for gpu_fb_writer (default build; the double-buffer
// scenario is compiled in when GPU_FB_DOUBLE_BUFFER_EN is defined).
module tb_gpu_fb_writer;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        enable       = 1'b0;
  logic        pixel_valid  = 1'b0;
  logic        pixel_ready;
  logic [10:0] pixel_x      = '0;
  logic [10:0] pixel_y      = '0;
  logic [7:0]  pixel_color  = '0;
  logic        pixel_draw   = 1'b0;
  logic        frame_end_in = 1'b0;
  logic [19:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        fb_wr_en;
  logic        fb_wr_ready  = 1'b0;
  logic        frame_done;
  logic [15:0] clip_count;
`ifdef GPU_FB_DOUBLE_BUFFER_EN
  logic        front_buffer;
`endif

  gpu_fb_writer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_color  (pixel_color),
    .pixel_draw   (pixel_draw),
    .frame_end_in (frame_end_in),
    .fb_wr_addr   (fb_wr_addr),
    .fb_wr_data   (fb_wr_data),
    .fb_wr_en     (fb_wr_en),
    .fb_wr_ready  (fb_wr_ready),
`ifdef GPU_FB_DOUBLE_BUFFER_EN
    .front_buffer (front_buffer),
`endif
    .frame_done   (frame_done),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int fd_cyc   = 0;
  int fd_count = 0;
  logic [27:0] wr_q[$];   // completed writes, {addr, data}

  always @(posedge clk) cyc++;

  // Record completed write handshakes and frame_done pulses mid-cycle.
  always @(negedge clk) begin
    if (reset && fb_wr_en && fb_wr_ready) begin
      wr_q.push_back({fb_wr_addr, fb_wr_data});
      wr_cyc = cyc;
    end
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input int y, input int c, input logic d, input logic fe);
    logic got;
    pixel_valid = 1'b1;
    pixel_x     = 11'(x);
    pixel_y     = 11'(y);
    pixel_color = 8'(c);
    pixel_draw  = d;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = pixel_ready;
    end
    check("send_ready", 32'(got), 32'd1);
    frame_end_in = fe;
    @(posedge clk); #1;
    pixel_valid  = 1'b0;
    pixel_draw   = 1'b0;
    frame_end_in = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int fd0;
    logic seen;

    // ---------------- reset values ----------------
    #1 reset = 1'b0;
    #1;
    check("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    check("rst_fb_wr_en",    32'(fb_wr_en),    32'd0);
    check("rst_fb_wr_addr",  32'(fb_wr_addr),  32'd0);
    check("rst_fb_wr_data",  32'(fb_wr_data),  32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    check("rst_clip_count",  32'(clip_count),  32'd0);
    enable      = 1'b1;
    fb_wr_ready = 1'b1;
    cycles(3);
    reset = 1'b1;
    @(negedge clk);
    check("first_edge_not_ready", 32'(pixel_ready), 32'd0);
    @(posedge clk); #1;

    // ---------------- single pixel latency ----------------
    wr_q.delete();
    send(3, 2, 8'h5A, 1'b1, 1'b0);
    @(negedge clk); check("lat_c0_en", 32'(fb_wr_en), 32'd0);
    @(negedge clk); check("lat_c1_en", 32'(fb_wr_en), 32'd0);
    @(negedge clk);
    check("lat_c2_en",   32'(fb_wr_en),   32'd1);
    check("lat_c2_addr", 32'(fb_wr_addr), 32'd1603);
    check("lat_c2_data", 32'(fb_wr_data), 32'h5A);
    cycles(5);
    check("lat_writes", 32'(wr_q.size()), 32'd1);

    // ---------------- backpressure then release ----------------
    wr_q.delete();
    fb_wr_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      pixel_valid = 1'b1; pixel_draw = 1'b1;
      pixel_x = 11'(acc); pixel_y = 11'd0; pixel_color = 8'(acc);
      @(negedge clk);
      if (pixel_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 32'd17);
    @(negedge clk);
    check("bp_ready_low", 32'(pixel_ready), 32'd0);
    check("bp_no_writes", 32'(wr_q.size()), 32'd0);
    @(posedge clk); #1;
    fb_wr_ready = 1'b1;
    for (int k = 0; k < 200 && acc < 32; k++) begin
      pixel_valid = 1'b1; pixel_draw = 1'b1;
      pixel_x = 11'(acc); pixel_y = 11'd0; pixel_color = 8'(acc);
      @(negedge clk);
      if (pixel_ready) acc++;
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0; pixel_draw = 1'b0;
    cycles(30);
    check("bp_total_writes", 32'(wr_q.size()), 32'd32);
    if (wr_q.size() == 32) begin
      for (int i = 0; i < 32; i++)
        check($sformatf("bp_order_%0d", i), 32'(wr_q[i]), {4'd0, 20'(i), 8'(i)});
    end

    // ---------------- clipping and discard ----------------
    wr_q.delete();
    send(800, 0,   8'h01, 1'b1, 1'b0);
    send(0,   600, 8'h02, 1'b1, 1'b0);
    send(5,   5,   8'h03, 1'b0, 1'b0);
    cycles(10);
    check("clip_no_writes", 32'(wr_q.size()), 32'd0);
    check("clip_count",     32'(clip_count),  32'd2);

    // ---------------- frame end with toggling ready ----------------
    wr_q.delete();
    fd0 = fd_count;
    fb_wr_ready = 1'b1;
    send(10, 1, 8'h11, 1'b1, 1'b0);
    fb_wr_ready = 1'b0;
    send(11, 1, 8'h22, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      fb_wr_ready = ~fb_wr_ready;
      @(posedge clk); #1;
    end
    fb_wr_ready = 1'b1;
    cycles(5);
    check("fe_writes", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("fe_w0", 32'(wr_q[0]), {4'd0, 20'd810, 8'h11});
      check("fe_w1", 32'(wr_q[1]), {4'd0, 20'd811, 8'h22});
    end
    check("fe_one_pulse",       32'(fd_count - fd0),  32'd1);
    check("fe_done_after_last", 32'(fd_cyc > wr_cyc), 32'd1);

    // ---------------- frame_end_in ignored in IDLE ----------------
    enable = 1'b0;
    cycles(10);
    fd0 = fd_count;
    frame_end_in = 1'b1;
    cycles(3);
    frame_end_in = 1'b0;
    cycles(10);
    check("idle_fe_ignored", 32'(fd_count), 32'(fd0));
    enable = 1'b1;
    cycles(2);

    // ---------------- reset mid-frame ----------------
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(20 + i, 0, 8'h40 + i, 1'b1, 1'b0);
    cycles(3);
    @(negedge clk);
    check("mid_queued_en", 32'(fb_wr_en), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_en",    32'(fb_wr_en),    32'd0);
    check("mid_rst_ready", 32'(pixel_ready), 32'd0);
    check("mid_rst_clip",  32'(clip_count),  32'd0);
    wr_q.delete();
    cycles(2);
    reset       = 1'b1;
    fb_wr_ready = 1'b1;
    cycles(20);
    check("mid_no_stale_writes", 32'(wr_q.size()), 32'd0);
    send(7, 0, 8'h77, 1'b1, 1'b0);
    cycles(10);
    check("mid_new_writes", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) check("mid_new_w0", 32'(wr_q[0]), {4'd0, 20'd7, 8'h77});

`ifdef GPU_FB_DOUBLE_BUFFER_EN
    // ---------------- double buffer ----------------
    wr_q.delete();
    send(0, 0, 8'hA1, 1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = frame_done; end
    check("db_f1_done",  32'(seen),         32'd1);
    check("db_f1_front", 32'(front_buffer), 32'd1);
    @(posedge clk); #1;
    send(0, 0, 8'hA2, 1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = frame_done; end
    check("db_f2_done",  32'(seen),         32'd1);
    check("db_f2_front", 32'(front_buffer), 32'd0);
    check("db_writes",   32'(wr_q.size()),  32'd2);
    if (wr_q.size() == 2) begin
      check("db_w0", 32'(wr_q[0]), {4'd0, 20'd0,      8'hA1});
      check("db_w1", 32'(wr_q[1]), {4'd0, 20'd480000, 8'hA2});
    end
`else
    seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_fb_writer.md
GPU_FB_WRITER -- requirements
Module: gpu_fb_writer

Interface
REQ-001 FB_WIDTH, 800, framebuffer width in pixels.
REQ-002 FB_HEIGHT, 600, framebuffer height in pixels.
REQ-003 FIFO_DEPTH, 16, write FIFO entries; power of two, 4 or greater.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  level; allows pixel acceptance.
REQ-007 pixel_valid  input  1  pixel beat valid (GPU output_valid).
REQ-008 pixel_ready  output  1  beat accepted when valid and ready both high (drives GPU out_ready).
REQ-009 pixel_x, pixel_y  input  11 each  pixel coordinates.
REQ-010 pixel_color  input  8  pixel value.
REQ-011 pixel_draw  input  1  1 = write pixel; 0 = discard beat.
REQ-012 frame_end_in  input  1  end-of-frame marker, sampled every cycle.
REQ-013 fb_wr_addr  output  20  linear framebuffer word address.
REQ-014 fb_wr_data  output  8  write data.
REQ-015 fb_wr_en  output  1  write request; held with addr/data stable until fb_wr_ready.
REQ-016 fb_wr_ready  input  1  memory accepts write this cycle.
REQ-017 frame_done  output  1  one-cycle pulse when a frame is fully written.
REQ-018 clip_count  output  16  saturating count of out-of-range draw pixels.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN.
REQ-020 IDLE: pixel_ready=0. Go to RUN when enable=1.
REQ-021 RUN: pixel_ready = enable AND FIFO not full. enable=0 returns to IDLE once the FIFO and the address stage are empty.
REQ-022 RUN: frame_end_in=1 goes to DRAIN. A pixel accepted in the same cycle is still written.
REQ-023 DRAIN: pixel_ready=0. When the FIFO, the address stage and the write output are all empty, pulse frame_done for 1 cycle, then go to RUN if enable=1, else IDLE.
REQ-024 frame_end_in is ignored in IDLE and DRAIN.
REQ-025 Accepted beat with pixel_draw=0: consumed, nothing written.
REQ-026 Accepted beat with pixel_x>=FB_WIDTH or pixel_y>=FB_HEIGHT: dropped. If pixel_draw=1, clip_count increments, saturating at 16'hFFFF.
REQ-027 Address stage: one register computes pixel_x + pixel_y*FB_WIDTH + base, 20-bit unsigned, then pushes {addr,color} into the FIFO.
REQ-028 Latency: an accepted pixel reaches fb_wr_en no earlier than 2 cycles after acceptance, with an empty FIFO and fb_wr_ready=1.
REQ-029 Throughput: 1 pixel per cycle while fb_wr_ready=1.
REQ-030 Ordering: writes are issued in acceptance order. No pixel is lost or duplicated under any fb_wr_ready pattern.
REQ-031 FIFO full: pixel_ready deasserts in the same cycle, combinational from the registered count. Skid capacity covers the in-flight address-stage entry.
REQ-032 base=0 unless REQ-036 applies.

Reset
REQ-033 Asserting reset takes effect immediately, including mid-frame. FSM goes to IDLE, FIFO is emptied, in-flight pixels are discarded.
REQ-034 Reset values: pixel_ready=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, clip_count=0, base select=0.
REQ-035 After reset deasserts, the first acceptance is possible no earlier than the second rising edge.

Configuration
REQ-036 Macro GPU_FB_DOUBLE_BUFFER_EN.
- Defined: base alternates between 0 and FB_WIDTH*FB_HEIGHT. The select toggles on each frame_done pulse.
- Port front_buffer (output, 1 bit) is added and equals the select bit after toggling.
REQ-037 Macro not defined: base is fixed at 0 and front_buffer is absent.

Verification
REQ-038 Reset, enable=1, then pixel (x=3, y=2, color=8'h5A, draw=1) with fb_wr_ready=1 -> fb_wr_en 2 cycles later, addr=1603, data=8'h5A.
REQ-039 Pixels x=0..31, y=0, fb_wr_ready held 0 -> pixel_ready drops after FIFO_DEPTH+1 accepts. Release fb_wr_ready -> addrs 0..31 written in order.
REQ-040 Pixel (x=800, y=0, draw=1), then (x=0, y=600, draw=1), then (x=5, y=5, draw=0) -> no writes, clip_count=2.
REQ-041 frame_end_in in the same cycle as the last accepted pixel, fb_wr_ready toggling 1010 -> last pixel written, then exactly one frame_done pulse.
REQ-042 Assert reset mid-frame with 5 pixels queued -> fb_wr_en=0 immediately, no further writes after release until new pixels arrive.
REQ-043 With GPU_FB_DOUBLE_BUFFER_EN defined, two frames each writing (0,0) -> addrs 0 then 480000, front_buffer=1 then 0.
